sdc_cmd_tx: RTL and testbench
=============================

# sdc_cmd_tx

SPI-mode SD card command engine. It sits directly after the dummy-clock stage in the SD init path: once the card has received its power-up clocks, this block frames a 48-bit command, shifts it out on MOSI, polls MISO for the R1 response, then issues 8 trailing clocks. The CRC7 is generated in hardware. It drives SCK/CS/MOSI itself, so the init controller muxes the SPI pins between the dummy-clock stage and this block.

## Interface
- HALF, 4: i_clk cycles per SCK half-period (≥2); one SCK bit = 2·HALF cycles
- RESP_TRIES, 8: maximum response bytes polled before timeout (1..15)
- i_clk  in  1  system clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_start  in  1  start request; sampled only in IDLE
- i_cmd  in  6  command index, latched on accepted start
- i_arg  in  32  command argument, latched on accepted start
- i_miso  in  1  card data out
- o_sck  out  1  SPI clock, mode 0 (idle low)
- o_cs  out  1  chip select, active low
- o_mosi  out  1  SPI data to card
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse at transaction end
- o_resp  out  8  R1 response byte; valid from o_done, held until next accepted start
- o_timeout  out  1  no response within RESP_TRIES bytes; valid and held like o_resp

## Operation
- Frame: byte0 = {2'b01, cmd}; bytes1-4 = arg, MSB first; byte5 = {crc7, 1'b1}. Bits go out MSB first, 48 bits total.
- CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 frame bits. It may be computed serially while shifting or up front, but it must be ready before bit 40.
- States and transitions:
  - IDLE → SETUP on i_start. Latch i_cmd and i_arg; clear o_timeout; set o_resp to 0xFF.
  - SETUP: CS low, SCK low, MOSI high for HALF cycles → TX.
  - TX: 48 bits → RESP.
  - RESP: clock bytes with MOSI=1 and shift in MISO.
    - After each byte, if bit7 of the byte is 0: store it in o_resp → TRAIL.
    - Otherwise increment the try counter. When the counter reaches RESP_TRIES, set o_resp=0xFF and o_timeout=1 → TRAIL.
  - TRAIL: CS high, MOSI high, 8 SCK clocks → DONE.
  - DONE: o_done=1 for one cycle → IDLE.
- i_start while not in IDLE is ignored. No queuing.
- The try counter and bit counter are sized for their parameter maxima. The bit counter wraps per byte in RESP.
- Reset values: o_sck=0, o_cs=1, o_mosi=1, o_busy=0, o_done=0, o_resp=0xFF, o_timeout=0; state IDLE.
- Reset mid-transaction forces the reset values on the next clock edge. No trailing clocks are issued and no o_done pulse is produced.

## Timing
- Each bit has a low phase (HALF cycles) followed by a high phase (HALF cycles). o_sck rises at the start of the high phase.
- MOSI changes only on the cycle SCK falls, or on entering the low phase of the first bit. It is stable across every rising edge.
- MISO is registered on the i_clk edge that drives o_sck 0→1.
- Timing of an accepted start:
  - o_busy is high from the cycle after the start is accepted through the o_done cycle inclusive.
  - o_cs goes low in the same cycle SETUP begins.
  - o_cs returns high at TRAIL entry.
- Total latency from accepted start to o_done = HALF + 96·HALF + 16·HALF·n + 16·HALF + 1 cycles, where n is the number of response bytes polled (1..RESP_TRIES).
- Edge conditions:
  - A response detected on the last allowed byte is a success: o_timeout=0.
  - i_start asserted during the o_done cycle is ignored; it is accepted on the next IDLE cycle.

## Test plan
- CMD0, arg 0x00000000, MISO returns 0xFF then 0x01 → MOSI frame 40 00 00 00 00 95, o_resp=0x01, o_timeout=0, n=2, o_done exactly at the computed latency.
- CMD8, arg 0x000001AA, MISO returns 0x01 on byte 1 → frame 48 00 00 01 AA 87, o_resp=0x01. Also check CMD55 arg 0 → CRC byte 0x65, and CMD41 arg 0x40000000 → 0x77.
- MISO held at 1, RESP_TRIES=8 → exactly 64 response clocks, o_resp=0xFF, o_timeout=1, then 8 trailing clocks with CS high.
- Response 0x00 arrives on the 8th byte → o_timeout=0, o_resp=0x00.
- i_start pulsed during TX → ignored, frame unaltered, single o_done.
- i_rst asserted mid-TX (bit 20) → next cycle cs=1, sck=0, mosi=1, busy=0, resp=0xFF. A new start afterwards completes normally.

Source files
------------

// File: rtl/sdc_cmd_tx_if.sv
// Pin and command bundle between the SD init controller and the command engine.
interface sdc_cmd_tx_if;
  logic        start;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        miso;
  logic        sck;
  logic        cs;
  logic        mosi;
  logic        busy;
  logic        done;
  logic [7:0]  resp;
  logic        timeout;

  modport master (
    output start, cmd, arg, miso,
    input  sck, cs, mosi, busy, done, resp, timeout
  );

  modport slave (
    input  start, cmd, arg, miso,
    output sck, cs, mosi, busy, done, resp, timeout
  );
endinterface

// File: rtl/sdc_cmd_tx.sv
// SPI-mode SD command engine: shifts out a 48-bit command with CRC7, polls MISO for
// the R1 byte, then gives 8 trailing clocks with CS released.
module sdc_cmd_tx #(
  parameter int HALF       = 4,
  parameter int RESP_TRIES = 8
) (
  input logic         i_clk,
  input logic         i_rst,
  sdc_cmd_tx_if.slave bus
);

  localparam int PH_W = $clog2(2 * HALF);
  localparam logic [PH_W-1:0] PH_PRE  = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(HALF);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF - 1);
  localparam logic [3:0]      TRY_LAST = 4'(RESP_TRIES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, TX, RESP, TRAIL, DONE} state_t;

  state_t          state, state_nx;
  logic [PH_W-1:0] ph;
  logic [5:0]      bits;
  logic [3:0]      tries;
  logic [47:0]     frame_sh;
  logic [7:0]      rx;
  logic [7:0]      resp;
  logic            timeout;
  logic            bit_end;
  logic            last_bit;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] build_frame(input logic [5:0] c, input logic [31:0] a);
    logic [39:0] head;
    head = {2'b01, c, a};
    return {head, crc7(head), 1'b1};
  endfunction

  assign bit_end  = (ph == PH_LAST);
  assign last_bit = (state == TX) ? (bits == 6'd47) : (bits == 6'd7);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.start) state_nx = SETUP;
      SETUP: if (ph == PH_PRE) state_nx = TX;
      TX:    if (bit_end && last_bit) state_nx = RESP;
      RESP:  if (bit_end && last_bit && (!rx[7] || tries == TRY_LAST)) state_nx = TRAIL;
      TRAIL: if (bit_end && last_bit) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control: phase/bit/try counters and the sticky result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ph      <= '0;
      bits    <= '0;
      tries   <= '0;
      resp    <= 8'hFF;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ph    <= '0;
          bits  <= '0;
          tries <= '0;
          if (bus.start) begin
            resp    <= 8'hFF;
            timeout <= 1'b0;
          end
        end
        SETUP: ph <= (ph == PH_PRE) ? '0 : ph + 1'b1;
        TX, RESP, TRAIL: begin
          ph <= bit_end ? '0 : ph + 1'b1;
          if (bit_end) bits <= last_bit ? 6'd0 : bits + 6'd1;
          if (state == RESP && bit_end && last_bit) begin
            if (!rx[7]) begin
              resp <= rx;
            end else begin
              tries <= tries + 4'd1;
              if (tries == TRY_LAST) begin
                resp    <= 8'hFF;
                timeout <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data: outgoing frame shifter and MISO capture on the SCK-rising clock edge.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && bus.start)
      frame_sh <= build_frame(bus.cmd, bus.arg);
    else if (state == TX && bit_end)
      frame_sh <= {frame_sh[46:0], 1'b1};
    if (state == RESP && ph == PH_PRE)
      rx <= {rx[6:0], bus.miso};
  end

  assign bus.sck     = (state == TX || state == RESP || state == TRAIL) && (ph >= PH_RISE);
  assign bus.cs      = !(state == SETUP || state == TX || state == RESP);
  assign bus.mosi    = (state == TX) ? frame_sh[47] : 1'b1;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.resp    = resp;
  assign bus.timeout = timeout;

endmodule

// File: tb/tb_sdc_cmd_tx.sv
// Bench for sdc_cmd_tx: directed vector table, hand-written corner sequences and
// random transactions checked against a card/CRC reference model.
module tb_sdc_cmd_tx;
  localparam int HALF       = 4;
  localparam int RESP_TRIES = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sdc_cmd_tx_if bus ();

  sdc_cmd_tx #(.HALF(HALF), .RESP_TRIES(RESP_TRIES)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [63:0] rsp;
    int          nrb;
    logic [47:0] exp_frame;
    logic [7:0]  exp_resp;
    logic        exp_to;
    int          exp_n;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return rem[6:0];
  endfunction

  function automatic logic [7:0] card_byte(input logic [63:0] rsp, input int nrb, input int j);
    if (j < nrb && j < 8) return rsp[63 - 8*j -: 8];
    return 8'hFF;
  endfunction

  function automatic void resp_ref(input logic [63:0] rsp, input int nrb,
                                   output logic [7:0] r, output logic to, output int n);
    logic [7:0] b;
    r = 8'hFF; to = 1'b1; n = RESP_TRIES;
    for (int j = 0; j < RESP_TRIES; j++) begin
      b = card_byte(rsp, nrb, j);
      if (!b[7]) begin
        r = b; to = 1'b0; n = j + 1;
        return;
      end
    end
  endfunction

  function automatic int lat_ref(input int n);
    return HALF + 96*HALF + 16*HALF*n + 16*HALF + 1;
  endfunction

  // Drives one transaction and plays the card; inj_rise >= 0 re-pulses start at that SCK rise.
  task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic [63:0] rsp,
                         input int nrb, input int inj_rise,
                         output logic [47:0] frame, output logic [7:0] r, output logic to,
                         output int rclk, output int tclk, output int lat,
                         output int ndone, output int bad);
    int   cyc, rises, b;
    logic prev, injected;
    logic [7:0] cb;
    cyc = 0; rises = 0; tclk = 0; lat = -1; ndone = 0; bad = 0;
    prev = 1'b0; injected = 1'b0; frame = '0; r = 'x; to = 'x;
    bus.cmd = c; bus.arg = a; bus.miso = 1'b1; bus.start = 1'b1;
    while (cyc < 3000 && !(lat >= 0 && cyc >= lat + 20)) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.sck && !prev) begin
        if (!bus.cs) begin
          if (rises < 48) frame = {frame[46:0], bus.mosi};
          rises++;
        end else begin
          tclk++;
          if (!bus.mosi) bad++;
        end
      end
      prev = bus.sck;
      if (rises >= 48) begin
        b = rises - 48;
        cb = card_byte(rsp, nrb, b / 8);
        bus.miso = cb[7 - (b % 8)];
      end else begin
        bus.miso = 1'b1;
      end
      if (inj_rise >= 0 && rises == inj_rise && !injected) begin
        bus.start = 1'b1;
        injected = 1'b1;
      end
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc; r = bus.resp; to = bus.timeout;
        end
      end
      if (bus.busy !== (lat < 0 || cyc == lat)) bad++;
    end
    rclk = rises - 48;
    bus.miso = 1'b1;
  endtask

  vec_t        tbl [6];
  logic [47:0] frame;
  logic [7:0]  r, er;
  logic        to, eto, prev, seen;
  logic [63:0] rsp;
  logic [5:0]  rc;
  logic [31:0] ra;
  logic [39:0] head;
  int          rclk, tclk, lat, ndone, bad, en, nrb, cyc, rises;

  initial begin
    tbl[0] = '{"cmd0",     6'd0,  32'h0000_0000, 64'hFF01_0000_0000_0000, 2, 48'h40_0000_0000_95, 8'h01, 1'b0, 2};
    tbl[1] = '{"cmd8",     6'd8,  32'h0000_01AA, 64'h0100_0000_0000_0000, 1, 48'h48_0000_01AA_87, 8'h01, 1'b0, 1};
    tbl[2] = '{"cmd55",    6'd55, 32'h0000_0000, 64'h0100_0000_0000_0000, 1, 48'h77_0000_0000_65, 8'h01, 1'b0, 1};
    tbl[3] = '{"cmd41",    6'd41, 32'h4000_0000, 64'h0000_0000_0000_0000, 1, 48'h69_4000_0000_77, 8'h00, 1'b0, 1};
    tbl[4] = '{"timeout",  6'd0,  32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 48'h40_0000_0000_95, 8'hFF, 1'b1, 8};
    tbl[5] = '{"last_try", 6'd0,  32'h0000_0000, 64'hFFFF_FFFF_FFFF_FF00, 8, 48'h40_0000_0000_95, 8'h00, 1'b0, 8};

    rst = 1'b1; bus.start = 1'b0; bus.cmd = '0; bus.arg = '0; bus.miso = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("reset.sck", bus.sck, 0);
    chk("reset.cs", bus.cs, 1);
    chk("reset.mosi", bus.mosi, 1);
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.resp", bus.resp, 8'hFF);
    chk("reset.timeout", bus.timeout, 0);

    foreach (tbl[i]) begin
      run_txn(tbl[i].cmd, tbl[i].arg, tbl[i].rsp, tbl[i].nrb, -1,
              frame, r, to, rclk, tclk, lat, ndone, bad);
      chk($sformatf("%s.frame", tbl[i].name), frame, tbl[i].exp_frame);
      chk($sformatf("%s.resp", tbl[i].name), r, tbl[i].exp_resp);
      chk($sformatf("%s.timeout", tbl[i].name), to, tbl[i].exp_to);
      chk($sformatf("%s.resp_clocks", tbl[i].name), rclk, 8 * tbl[i].exp_n);
      chk($sformatf("%s.trail_clocks", tbl[i].name), tclk, 8);
      chk($sformatf("%s.latency", tbl[i].name), lat, lat_ref(tbl[i].exp_n));
      chk($sformatf("%s.done_pulses", tbl[i].name), ndone, 1);
      chk($sformatf("%s.pin_errors", tbl[i].name), bad, 0);
    end

    // Start re-pulsed mid-TX must not disturb the frame or cause a second transaction.
    run_txn(6'd8, 32'h0000_01AA, 64'h0100_0000_0000_0000, 1, 10,
            frame, r, to, rclk, tclk, lat, ndone, bad);
    chk("inject.frame", frame, 48'h48_0000_01AA_87);
    chk("inject.done_pulses", ndone, 1);
    chk("inject.latency", lat, lat_ref(1));
    chk("inject.pin_errors", bad, 0);

    // Reset at bit 20 of TX.
    bus.cmd = 6'd17; bus.arg = 32'h1234_5678; bus.miso = 1'b1; bus.start = 1'b1;
    cyc = 0; rises = 0; prev = 1'b0;
    while (rises < 20 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++; bus.start = 1'b0;
      if (bus.sck && !prev) rises++;
      prev = bus.sck;
    end
    chk("rst_mid.reached_bit20", rises, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid.cs", bus.cs, 1);
    chk("rst_mid.sck", bus.sck, 0);
    chk("rst_mid.mosi", bus.mosi, 1);
    chk("rst_mid.busy", bus.busy, 0);
    chk("rst_mid.resp", bus.resp, 8'hFF);
    ndone = 0; bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
      if (bus.sck || !bus.cs) bad++;
    end
    chk("rst_mid.no_done", ndone, 0);
    chk("rst_mid.quiet_pins", bad, 0);
    run_txn(6'd55, 32'h0, 64'hFF01_0000_0000_0000, 2, -1, frame, r, to, rclk, tclk, lat, ndone, bad);
    chk("after_rst.frame", frame, 48'h77_0000_0000_65);
    chk("after_rst.resp", r, 8'h01);
    chk("after_rst.latency", lat, lat_ref(2));

    // Start held during the done cycle is ignored there and taken on the next idle cycle.
    bus.cmd = 6'd8; bus.arg = 32'h1AA; bus.miso = 1'b0; bus.start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++; bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk("dstart.first_done", seen, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("dstart.ignored_in_done", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("dstart.accepted_next", bus.busy, 1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    chk("dstart.second_done", seen, 1);
    chk("dstart.resp", bus.resp, 8'h00);
    bus.miso = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 16; k++) begin
      rc  = 6'($urandom);
      ra  = $urandom;
      nrb = $urandom_range(0, 8);
      for (int j = 0; j < 8; j++)
        rsp[63 - 8*j -: 8] = {($urandom_range(0, 3) != 0), 7'($urandom)};
      head = {2'b01, rc, ra};
      resp_ref(rsp, nrb, er, eto, en);
      run_txn(rc, ra, rsp, nrb, -1, frame, r, to, rclk, tclk, lat, ndone, bad);
      chk($sformatf("rnd%0d.frame", k), frame, {head, crc_ref(head), 1'b1});
      chk($sformatf("rnd%0d.resp", k), r, er);
      chk($sformatf("rnd%0d.timeout", k), to, eto);
      chk($sformatf("rnd%0d.resp_clocks", k), rclk, 8 * en);
      chk($sformatf("rnd%0d.latency", k), lat, lat_ref(en));
      chk($sformatf("rnd%0d.pins", k), bad + ndone + tclk, 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
